// File: rtl/adaptive_fxp_pkg.sv
// +--------------------------------------------------------------------------+
// | adaptive_fxp_pkg                                                         |
// | Shared state encoding, default sizing and sign-magnitude helpers for     |
// | the adaptive fixed-point MAC processing element.                         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package adaptive_fxp_pkg;

    localparam int c_DEF_DEC_PART  = 3;
    localparam int c_DEF_MANT_PART = 12;
    localparam int c_DEF_LANES     = 4;
    localparam int c_DEF_GUARD     = 4;
    localparam int c_DEF_MAX_LEN   = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Sign of (a + b) in sign-magnitude; a zero result is always positive.
    function automatic logic sm_result_sign(
        input logic a_sign,
        input logic b_sign,
        input logic a_ge_b,
        input logic is_zero
    );
        if (is_zero)
            return 1'b0;
        else if (a_sign == b_sign)
            return a_sign;
        else
            return a_ge_b ? a_sign : b_sign;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sm_acc_lane.sv
// +--------------------------------------------------------------------------+
// | sm_acc_lane                                                              |
// | One MAC lane: sign-magnitude multiply and accumulate, two's-complement   |
// | result. Saturation enabled by macro ADAPTIVE_FXP_PE_SAT_EN.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sm_acc_lane
    import adaptive_fxp_pkg::*;
#(
    parameter int DEC_PART  = c_DEF_DEC_PART,
    parameter int MANT_PART = c_DEF_MANT_PART,
    parameter int GUARD     = c_DEF_GUARD
) (
    input  logic                                         clock,
    input  logic                                         rstn,
    input  logic                                         clear,
    input  logic                                         enable,
    input  logic [DEC_PART+MANT_PART:0]                  image,
    input  logic [DEC_PART+MANT_PART:0]                  weight,
    output logic [2*(DEC_PART+MANT_PART)+GUARD:0]        acc_out,
    output logic                                         sat
);

    localparam int MW  = DEC_PART + MANT_PART;
    localparam int PMW = 2 * MW;
    localparam int AMW = PMW + GUARD;

    logic           r_sign;
    logic [AMW-1:0] r_mag;

    logic [PMW-1:0] w_prod_mag;
    logic           w_prod_sign;
    logic [AMW-1:0] w_prod_ext;
    logic           w_a_ge;
    logic [AMW-1:0] w_diff;
    logic [AMW-1:0] w_new_mag;
    logic           w_new_sign;

    assign w_prod_mag  = {{MW{1'b0}}, image[MW-1:0]} * {{MW{1'b0}}, weight[MW-1:0]};
    assign w_prod_sign = image[MW] ^ weight[MW];
    assign w_prod_ext  = {{GUARD{1'b0}}, w_prod_mag};
    assign w_a_ge      = (r_mag >= w_prod_ext);
    assign w_diff      = w_a_ge ? (r_mag - w_prod_ext) : (w_prod_ext - r_mag);

`ifdef ADAPTIVE_FXP_PE_SAT_EN
    logic [AMW:0] w_sum;
    logic         w_ovf;
    logic         r_sat;

    assign w_sum = {1'b0, r_mag} + {1'b0, w_prod_ext};

    always_comb begin
        w_ovf     = 1'b0;
        w_new_mag = w_diff;
        if (r_sign == w_prod_sign) begin
            w_ovf     = w_sum[AMW];
            w_new_mag = w_ovf ? {AMW{1'b1}} : w_sum[AMW-1:0];
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn)
            r_sat <= 1'b0;
        else if (clear)
            r_sat <= 1'b0;
        else if (enable && w_ovf)
            r_sat <= 1'b1;
    end

    assign sat = r_sat;
`else
    logic [AMW-1:0] w_sum;

    // Natural AMW-bit add gives the modulo-2^AMW wrap.
    assign w_sum = r_mag + w_prod_ext;

    always_comb begin
        w_new_mag = w_diff;
        if (r_sign == w_prod_sign)
            w_new_mag = w_sum;
    end

    assign sat = 1'b0;
`endif

    assign w_new_sign = sm_result_sign(r_sign, w_prod_sign, w_a_ge, (w_new_mag == '0));

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
        end else if (clear) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
        end else if (enable) begin
            r_sign <= w_new_sign;
            r_mag  <= w_new_mag;
        end
    end

    assign acc_out = r_sign ? -{1'b0, r_mag} : {1'b0, r_mag};

endmodule

`default_nettype wire

// File: rtl/adaptive_fxp_mac_pe.sv
// +--------------------------------------------------------------------------+
// | adaptive_fxp_mac_pe                                                      |
// | Multi-lane sign-magnitude dot-product PE with systolic pass-through.     |
// | Lane saturation enabled by macro ADAPTIVE_FXP_PE_SAT_EN. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module adaptive_fxp_mac_pe
    import adaptive_fxp_pkg::*;
#(
    parameter int DEC_PART  = c_DEF_DEC_PART,
    parameter int MANT_PART = c_DEF_MANT_PART,
    parameter int LANES     = c_DEF_LANES,
    parameter int GUARD     = c_DEF_GUARD,
    parameter int MAX_LEN   = c_DEF_MAX_LEN,
    localparam int W        = DEC_PART + MANT_PART + 1,
    localparam int PW       = 2 * (DEC_PART + MANT_PART) + 1,
    localparam int AW       = PW + GUARD,
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [LW-1:0]         len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*W-1:0]    image,
    input  logic [LANES*W-1:0]    weight,
    output logic [LANES*W-1:0]    image_out,
    output logic [LANES*W-1:0]    weight_out,
    output logic                  valid_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*AW-1:0]   out_acc,
    output logic [LANES-1:0]      out_sat,
    output logic                  busy
);

    state_t          r_state;
    state_t          w_state_next;
    logic [LW-1:0]   r_count;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   w_count_inc;
    logic            w_start_acc;
    logic            w_beat;
    logic [LANES*W-1:0] r_image_out;
    logic [LANES*W-1:0] r_weight_out;
    logic            r_valid_out;

    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_beat      = in_valid && in_ready;
    assign w_count_inc = r_count + LW'(1);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = (len == '0) ? ST_DONE : ST_ACCUM;
            ST_ACCUM: if (w_beat && (w_count_inc == r_len)) w_state_next = ST_DONE;
            ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_ACCUM);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
            r_len   <= '0;
        end else if (w_start_acc) begin
            r_count <= '0;
            r_len   <= len;
        end else if (w_beat) begin
            r_count <= w_count_inc;
        end
    end

    // Systolic forward of the last accepted beat; valid_out pulses once per beat.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_image_out  <= '0;
            r_weight_out <= '0;
            r_valid_out  <= 1'b0;
        end else begin
            r_valid_out <= w_beat;
            if (w_beat) begin
                r_image_out  <= image;
                r_weight_out <= weight;
            end
        end
    end

    assign image_out  = r_image_out;
    assign weight_out = r_weight_out;
    assign valid_out  = r_valid_out;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            sm_acc_lane #(
                .DEC_PART  (DEC_PART),
                .MANT_PART (MANT_PART),
                .GUARD     (GUARD)
            ) u_lane (
                .clock   (clock),
                .rstn    (rstn),
                .clear   (w_start_acc),
                .enable  (w_beat),
                .image   (image[gi*W +: W]),
                .weight  (weight[gi*W +: W]),
                .acc_out (out_acc[gi*AW +: AW]),
                .sat     (out_sat[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire
